// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle main control unit and the ALU-control decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALUX_FUNCT = 2'b00;
  localparam logic [1:0] ALUX_ADD   = 2'b10;
  localparam logic [1:0] ALUX_SUB   = 2'b01;

  localparam logic [1:0] ALUB_RT   = 2'b00;
  localparam logic [1:0] ALUB_ONE  = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;
  localparam logic [1:0] ALUB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_ADDI, OP_HALT: is_legal_op = 1'b1;
      default:                                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready; flags the wait cycle that
// reaches MEM_TIMEOUT so the controller can abort with a bus error.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= 8'd0;
    end else if (tick) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // The MEM_TIMEOUT-th consecutive wait cycle is the last one tolerated.
  assign timeout = tick && (count_reg == LIMIT);

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle main control FSM for the 16-bit RISC core.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the core and raise sticky illegal_op.
module main_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALUOPX_W    = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IorD,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOPX_W-1:0] ALUOpcodeX,
  output logic [1:0]          PCSource,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic                bus_err,
  output logic                halted
);

  state_t              state_reg, state_next;
  logic [OPCODE_W-1:0] opcode_reg;
  logic                bus_err_reg;
  logic                wait_tick, wait_clear, wait_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RESET;
      opcode_reg  <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) begin
        opcode_reg <= Opcode;
      end
      if (wait_timeout) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_reg <= 1'b0;
    end else if (state_reg == ST_DECODE && !is_legal_op(Opcode)) begin
      illegal_reg <= 1'b1;
    end
  end

  assign illegal_op = illegal_reg;
`endif

  assign wait_tick  = (state_reg == ST_FETCH || state_reg == ST_MEM) && !mem_ready;
  assign wait_clear = (state_next != state_reg);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear),
    .tick   (wait_tick),
    .timeout(wait_timeout)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET: state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)         state_next = ST_DECODE;
        else if (wait_timeout) state_next = ST_HALT;
      end
      ST_DECODE: begin
        // Decode steers on the live opcode; opcode_reg only holds it from EXEC on.
        if (Opcode == OP_HALT) state_next = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else if (!is_legal_op(Opcode)) state_next = ST_HALT;
`endif
        else state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode_reg)
          OP_RTYPE, OP_ADDI: state_next = ST_WB;
          OP_LW, OP_SW:      state_next = ST_MEM;
          default:           state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)         state_next = (opcode_reg == OP_LW) ? ST_WB : ST_FETCH;
        else if (wait_timeout) state_next = ST_HALT;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RESET;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = ALUB_RT;
    ALUOpcodeX = ALUX_FUNCT;
    PCSource   = PCS_ALU;
    case (state_reg)
      ST_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = ALUB_ONE;
        ALUOpcodeX = ALUX_ADD;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcB    = ALUB_BOFF;
        ALUOpcodeX = ALUX_ADD;
      end
      ST_EXEC: begin
        case (opcode_reg)
          OP_RTYPE: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = ALUB_RT;
            ALUOpcodeX = ALUX_FUNCT;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = ALUB_IMM;
            ALUOpcodeX = ALUX_ADD;
          end
          OP_BEQ: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = ALUB_RT;
            ALUOpcodeX = ALUX_SUB;
            PCSource   = PCS_ALUOUT;
            PCWrite    = Zero;
          end
          OP_JMP: begin
            PCSource = PCS_JUMP;
            PCWrite  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        IorD     = 1'b1;
        MemRead  = (opcode_reg == OP_LW);
        MemWrite = (opcode_reg == OP_SW);
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (opcode_reg == OP_RTYPE);
        MemtoReg = (opcode_reg == OP_LW);
      end
      default: ;
    endcase
  end

  assign bus_err = bus_err_reg;
  assign halted  = (state_reg == ST_HALT);

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed scenarios plus randomized traffic
// against an instruction-step model. Honours CTRL_ILLEGAL_TRAP_EN.
module tb_main_ctrl_fsm;

  localparam int TO = 15;
  localparam int PH_RST = 0, PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5, PH_H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Opcode = 4'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOpcodeX, PCSource;
  logic       bus_err, halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int checks = 0;
  int failures = 0;

  main_ctrl_fsm dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOpcodeX(ALUOpcodeX), .PCSource(PCSource),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [16:0] dutv;
  assign dutv = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg,
                 ALUSrcA, ALUSrcB, ALUOpcodeX, PCSource, bus_err, halted};

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model: instruction steps ----------------
  int         m_ph = PH_RST;
  logic [3:0] m_op = 4'd0;
  int         m_wait = 0;
  logic       m_be = 1'b0;
  logic       m_ill = 1'b0;

  function automatic logic legal(input logic [3:0] op);
    return (op <= 4'd5) || (op == 4'hF);
  endfunction

  always @(posedge clk) begin : model
    int ph_n, w_n;
    logic be_n, ill_n;
    logic [3:0] op_n;
    ph_n = m_ph; w_n = m_wait; be_n = m_be; ill_n = m_ill; op_n = m_op;
    if (rst) begin
      ph_n = PH_RST; w_n = 0; be_n = 0; ill_n = 0; op_n = 4'd0;
    end else begin
      case (m_ph)
        PH_RST: ph_n = PH_F;
        PH_F, PH_M: begin
          if (mem_ready) begin
            w_n = 0;
            if (m_ph == PH_F)      ph_n = PH_D;
            else if (m_op == 4'd1) ph_n = PH_W;
            else                   ph_n = PH_F;
          end else if (m_wait + 1 >= TO) begin
            ph_n = PH_H; be_n = 1; w_n = 0;
          end else begin
            w_n = m_wait + 1;
          end
        end
        PH_D: begin
          op_n = Opcode;
          if (Opcode == 4'hF) ph_n = PH_H;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else if (!legal(Opcode)) begin ph_n = PH_H; ill_n = 1; end
`endif
          else ph_n = PH_E;
        end
        PH_E: begin
          if (m_op == 4'd0 || m_op == 4'd5)      ph_n = PH_W;
          else if (m_op == 4'd1 || m_op == 4'd2) ph_n = PH_M;
          else                                   ph_n = PH_F;
        end
        PH_W: ph_n = PH_F;
        default: ph_n = PH_H;
      endcase
    end
    m_ph <= ph_n; m_wait <= w_n; m_be <= be_n; m_ill <= ill_n; m_op <= op_n;
  end

  function automatic logic [16:0] expv(input int ph, input logic [3:0] op, input logic z,
                                       input logic rdy, input logic be);
    logic pcw, irw, mr, mw, iord, rw, rd, m2r, sa, hl;
    logic [1:0] sb, ax, ps;
    {pcw, irw, mr, mw, iord, rw, rd, m2r, sa, hl} = '0;
    sb = 2'b00; ax = 2'b00; ps = 2'b00;
    case (ph)
      PH_F: begin mr = 1; sb = 2'b01; ax = 2'b10; pcw = rdy; irw = rdy; end
      PH_D: begin sb = 2'b11; ax = 2'b10; end
      PH_E: begin
        if (op == 4'd0) begin sa = 1; end
        else if (op == 4'd1 || op == 4'd2 || op == 4'd5) begin sa = 1; sb = 2'b10; ax = 2'b10; end
        else if (op == 4'd3) begin sa = 1; ax = 2'b01; ps = 2'b01; pcw = z; end
        else if (op == 4'd4) begin ps = 2'b10; pcw = 1; end
      end
      PH_M: begin iord = 1; mr = (op == 4'd1); mw = (op == 4'd2); end
      PH_W: begin rw = 1; rd = (op == 4'd0); m2r = (op == 4'd1); end
      PH_H: hl = 1;
      default: ;
    endcase
    return {pcw, irw, mr, mw, iord, rw, rd, m2r, sa, sb, ax, ps, be, hl};
  endfunction

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    chk($sformatf("outs ph=%0d op=%h", m_ph, m_op), dutv, expv(m_ph, m_op, Zero, mem_ready, m_be));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_op", {16'd0, illegal_op}, {16'd0, m_ill});
`endif
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic rdy, input logic [3:0] op, input logic z);
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; Opcode = op; Zero = z;
    #1;
  endtask

  int mem_cycles;

  initial begin
    // Reset held two cycles, then released.
    drive(1, 1, 4'd0, 0);  chk("rst_outs", dutv, 17'd0);
    drive(0, 1, 4'd0, 0);  chk("rst_last", dutv, 17'd0);
    drive(0, 1, 4'd0, 0);  chk("fetch_memread", {16'd0, MemRead}, 17'd1);
                           chk("fetch_alux", {15'd0, ALUOpcodeX}, 17'd2);
    // R-type
    drive(0, 1, 4'd0, 0);  chk("dec_alusrcb", {15'd0, ALUSrcB}, 17'd3);
    drive(0, 1, 4'd0, 0);  chk("r_exec_alux", {15'd0, ALUOpcodeX, RegWrite}, 17'd0);
    drive(0, 1, 4'd0, 0);  chk("r_wb_regs", {15'd0, RegWrite, RegDst}, 17'd3);
    drive(0, 1, 4'd1, 0);  chk("r_next_fetch", {16'd0, MemRead}, 17'd1);
    // LW with three wait cycles in MEM
    drive(0, 1, 4'd1, 0);
    drive(0, 1, 4'd1, 0);
    mem_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 3), 4'd1, 0);
      if (IorD && MemRead) mem_cycles++;
    end
    chk("lw_mem_cycles", 17'(mem_cycles), 17'd4);
    drive(0, 1, 4'd3, 0);  chk("lw_wb", {14'd0, RegWrite, MemtoReg, bus_err}, 17'd6);
    // BEQ taken, then not taken
    drive(0, 1, 4'd3, 0);  chk("beq1_fetch", {16'd0, IRWrite}, 17'd1);
    drive(0, 1, 4'd3, 0);
    drive(0, 1, 4'd3, 1);  chk("beq_taken", {12'd0, PCWrite, ALUOpcodeX, PCSource}, 17'b1_01_01);
    drive(0, 1, 4'd3, 0);  chk("beq1_back", {16'd0, MemRead}, 17'd1);
    drive(0, 1, 4'd3, 0);
    drive(0, 1, 4'd3, 0);  chk("beq_nottaken", {12'd0, PCWrite, ALUOpcodeX, PCSource}, 17'b0_01_01);
    drive(0, 1, 4'd9, 0);  chk("beq2_back", {16'd0, MemRead}, 17'd1);
    // Illegal opcode 1001
    drive(0, 1, 4'd9, 0);
    drive(0, 1, 4'd9, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_trap", {15'd0, illegal_op, halted}, 17'd3);
`else
    chk("illegal_nop", {12'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite}, 17'd0);
    drive(0, 1, 4'd9, 0);  chk("illegal_back", {16'd0, MemRead}, 17'd1);
`endif
    // Fetch timeout
    drive(1, 1, 4'd0, 0);
    drive(0, 0, 4'd0, 0);
    for (int i = 0; i < TO; i++) drive(0, 0, 4'd0, 0);
    chk("timeout_pre", {15'd0, bus_err, halted}, 17'd0);
    drive(0, 0, 4'd0, 0);  chk("timeout_halt", {15'd0, bus_err, halted}, 17'd3);
    drive(1, 1, 4'd0, 0);
    drive(0, 1, 4'd0, 0);  chk("timeout_rstclr", {15'd0, bus_err, halted}, 17'd0);
    // Randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        logic [3:0] ops [9];
        int pct;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd12, 4'd15};
        pct = (blk % 2 == 0) ? 90 : 35;
        drive(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < pct),
              ops[($urandom_range(0, 99) < 3) ? 8 : $urandom_range(0, 7)],
              1'($urandom_range(0, 1)));
      end
    end
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
